fsm_detector_mooreo: RTL and testbench

FSM_DETECTOR_MOOREO -- requirements
Module: fsm_detector_mooreo

---
 rtl/fsm_detector_mooreo.sv | 48 ++++
 tb/tb_fsm_detector_mooreo.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fsm_detector_mooreo.sv
// Moore FSM that flags the serial pattern 1-0-1 on `in`, with overlapping hits.
// `out` is decoded from the current state only.
//
//  state | meaning
//  S0    | no prefix matched
//  S1    | "1" matched
//  S2    | "10" matched
//  S3    | "101" matched, out=1
module fsm_detector_mooreo (
   input  logic in,
   input  logic reset,
   input  logic clk,
   output logic out
);

   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10,
      S3 = 2'b11
   } state_t;

   state_t state;
   state_t state_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S0;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = S0;
      out       = 1'b0;
      case (state)
         S0:      state_nxt = in ? S1 : S0;
         S1:      state_nxt = in ? S1 : S2;
         S2:      state_nxt = in ? S3 : S0;
         // trailing "1" of a hit doubles as the start of the next match
         S3:      state_nxt = in ? S1 : S2;
         default: state_nxt = S0;
      endcase
      out = (state == S3);
   end

endmodule

// File: tb/tb_fsm_detector_mooreo.sv
// Scoreboard bench for fsm_detector_mooreo: the driver queues the expected `out`
// for each bit, the monitor checks it just after the sampling edge.
module tb_fsm_detector_mooreo;

   logic clk = 1'b0;
   logic clk_en = 1'b0;
   logic reset = 1'b0;
   logic in = 1'b0;
   logic out;

   int n_pass = 0;
   int n_total = 0;
   bit exp_q[$];
   bit mon_en = 1'b0;

   fsm_detector_mooreo dut (
      .in    (in),
      .reset (reset),
      .clk   (clk),
      .out   (out)
   );

   always #5 if (clk_en) clk = ~clk;

   task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
   endtask

   // Monitor: one expected value per sampled bit, compared after the edge.
   always @(posedge clk) begin
      #1;
      if (mon_en && exp_q.size() > 0) begin
         automatic bit e = exp_q.pop_front();
         check("out_seq", {1'b0, out}, {1'b0, e});
      end
   end

   task automatic drive_bit(input bit b, input bit e);
      @(negedge clk);
      in = b;
      exp_q.push_back(e);
   endtask

   task automatic drive_seq(input string bits, input string exps);
      for (int i = 0; i < bits.len(); i++)
         drive_bit(bits[i] == "1", exps[i] == "1");
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 20) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (exp_q.size() > 0) begin
         $display("FAIL %s: scoreboard not drained, %0d entries left", name, exp_q.size());
         n_total++;
         exp_q.delete();
      end
   endtask

   // Reset asserted between edges; out and state must clear without a clock.
   task automatic mid_reset(input string name);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check({name, "_out"}, {1'b0, out}, 2'b00);
      check({name, "_state"}, dut.state, 2'b00);
      @(negedge clk);
      in = 1'b0;
      reset = 1'b0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   initial begin
      // 5 ns reset pulse with the clock idle
      #2;
      reset = 1'b1;
      #1;
      check("por_out_during", {1'b0, out}, 2'b00);
      check("por_state_during", dut.state, 2'b00);
      #4;
      reset = 1'b0;
      #1;
      check("por_out_after", {1'b0, out}, 2'b00);
      check("por_state_after", dut.state, 2'b00);

      clk_en = 1'b1;
      mon_en = 1'b1;

      drive_seq("01010101", "00010101");
      drain("alt_0101");

      mid_reset("rst_a");
      drive_seq("11101", "00001");
      drain("ones_then_01");

      mid_reset("rst_b");
      drive_seq("1001000", "0000000");
      drain("no_false_hit");

      mid_reset("rst_c");
      drive_seq("10101", "00101");
      drain("overlap_10101");

      // reach S3, then reset mid-cycle; retained prefix must be gone
      mid_reset("rst_d");
      drive_seq("101", "001");
      drain("reach_s3");
      check("s3_out_before_reset", {1'b0, out}, 2'b01);
      mid_reset("rst_in_s3");
      drive_seq("01", "00");
      drain("after_s3_reset");

      // hold reset across clock edges with in=1: state must stay S0
      @(negedge clk);
      reset = 1'b1;
      in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("held_reset_out", {1'b0, out}, 2'b00);
      check("held_reset_state", dut.state, 2'b00);
      @(negedge clk);
      reset = 1'b0;
      in = 1'b0;
      drive_seq("0101", "0001");
      drain("post_held_reset");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
